alu_mdu_seq: RTL and testbench
==============================

// Module: alu_mdu_seq
// PURPOSE
//  XLEN-parametrised execute unit for the RV32I/M pipeline EX stage. Registered
//  ALU ops (add..sltu, flags {v,c,n,z}) plus iterative RV32M mul/div/rem.
//  Valid/ready on both sides, one op in flight, flush input for branch kill.
//  Hazard unit stalls EX on in_ready=0.
// PARAMETERS
//  XLEN     32             operand/result width (>=8, power of 2)
//  SHAMT_W  $clog2(XLEN)   shift-amount bits taken from b (derived, do not override)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous reset, active low
//  flush      in   1     abort in-flight op, drop pending result
//  in_valid   in   1     a/b/op valid
//  in_ready   out  1     unit can accept (= state==IDLE & ~flush)
//  a          in   XLEN  operand A
//  b          in   XLEN  operand B
//  op         in   5     0_0000 add, 0_0001 sub, 0_0010 and, 0_0011 or, 0_0100 xor,
//                        0_0101 slt, 0_0110 sll, 0_0111 srl, 0_1000 sra, 0_1001 sltu,
//                        1_0000 mul, 1_0001 mulh, 1_0010 mulhsu, 1_0011 mulhu,
//                        1_0100 div, 1_0101 divu, 1_0110 rem, 1_0111 remu
//  out_valid  out  1     result/flags valid
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  result
//  flags      out  4     {v,c,n,z}
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=0, flags=0, counters/accumulators=0.
//  FSM IDLE/MUL/DIV/DONE. Accept = in_valid & in_ready; a,b,op latched.
//   IDLE: accept base op -> DONE next edge (result 1 cycle after accept);
//         accept mul* -> MUL; div*/rem* -> DIV; unlisted op -> DONE, result=0,flags=0.
//   MUL: XLEN shift-add steps on operand magnitudes, 2*XLEN product; sign fixup on
//        exit; mul=low half, others=high half. -> DONE after XLEN cycles.
//   DIV: XLEN restoring steps on magnitudes; quotient sign=a^b, remainder sign=a.
//        -> DONE after XLEN cycles. mul/div latency = XLEN+1 from accept.
//   DONE: out_valid=1, result/flags stable until out_ready=1, then -> IDLE.
//        No new accept in the out_ready cycle (in_ready=0 in DONE).
//  Base ops: sum = a + (op[0]?~b:b) + op[0] on XLEN+1 bits; shifts use b[SHAMT_W-1:0];
//   sra arithmetic; slt = sum[XLEN-1]^v; sltu = ~c (sub borrow), zero-extended.
//  Flags: z=(result==0), n=result[XLEN-1]; c=carry-out, v=signed overflow for
//   add/sub/slt/sltu only, else c=v=0. mul/div: c=v=0.
//  Div by zero: div/divu quotient all ones, rem/remu = a; DIV completes early in
//   1 cycle (DONE at accept+2).
//  Signed overflow: div(MIN,-1)=MIN, rem(MIN,-1)=0; normal iterative path, no trap.
//  flush: any state -> IDLE next edge, out_valid=0, result dropped; flush with
//   in_valid same cycle: not accepted. flush dominates out_ready.
//  rst_n low mid-op: immediate return to reset values, op discarded.
// TESTING
//  reset low during DIV cycle 10 -> out_valid=0, in_ready=1 on release, result=0.
//  add 0x7FFFFFFF+1 -> 1 cycle later result 0x80000000, flags v=1,c=0,n=1,z=0;
//   sub 5-5 -> 0, flags z=1,c=1.
//  mulh 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; mulhu same -> 0xFFFFFFFE; out_valid
//   exactly 33 cycles after accept.
//  div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0; divu 7/0 -> 0xFFFFFFFF,
//   remu 7/0 -> 7, out_valid 2 cycles after accept.
//  DONE with out_ready=0 for 5 cycles -> result stable, in_ready=0; out_ready=1 ->
//   IDLE next edge; rem -7/2 -> 0xFFFFFFFF (-1).
//  flush at MUL cycle 4 with in_valid=1 -> no out_valid, no accept that cycle;
//   next sll 1<<35(b=35) accepted -> result 8 (shamt 3).

Source files
------------

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: EX-stage unit, registered ALU ops plus iterative RV32M mul/div/rem.
// Ports: clk, rst_n, flush, in_valid/in_ready, a, b, op, out_valid/out_ready, result, flags {v,c,n,z}.
module alu_mdu_seq #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_SLT    = 5'h05;
    localparam logic [4:0] OP_SLL    = 5'h06;
    localparam logic [4:0] OP_SRL    = 5'h07;
    localparam logic [4:0] OP_SRA    = 5'h08;
    localparam logic [4:0] OP_SLTU   = 5'h09;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_REM    = 5'h16;

    logic [1:0]          state;
    logic [SHAMT_W-1:0]  cnt;
    logic [4:0]          opr;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     mcand;
    logic [XLEN-1:0]     aa;
    logic                negq;
    logic                negr;

    assign in_ready  = (state == S_IDLE) & ~flush;
    assign out_valid = (state == S_DONE);

    // ---------------- base ALU ----------------
    logic [XLEN-1:0]    bx;
    logic [XLEN:0]      sum;
    logic               cout;
    logic               ovf;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    base_res;
    logic               cv_en;
    logic [3:0]         base_fl;

    assign bx    = op[0] ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, bx} + {{XLEN{1'b0}}, op[0]};
    assign cout  = sum[XLEN];
    assign ovf   = (a[XLEN-1] == bx[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        base_res = '0;
        cv_en    = 1'b0;
        case (op)
            OP_ADD:  begin base_res = sum[XLEN-1:0]; cv_en = 1'b1; end
            OP_SUB:  begin base_res = sum[XLEN-1:0]; cv_en = 1'b1; end
            OP_AND:  base_res = a & b;
            OP_OR:   base_res = a | b;
            OP_XOR:  base_res = a ^ b;
            OP_SLT: begin
                base_res = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ ovf};
                cv_en    = 1'b1;
            end
            OP_SLL:  base_res = a << shamt;
            OP_SRL:  base_res = a >> shamt;
            OP_SRA:  base_res = $signed(a) >>> shamt;
            OP_SLTU: begin
                base_res = {{(XLEN-1){1'b0}}, ~cout};
                cv_en    = 1'b1;
            end
            default: base_res = '0;
        endcase
    end

    assign base_fl = {ovf & cv_en, cout & cv_en,
                      base_res[XLEN-1], base_res == '0};

    // ---------------- operand decode ----------------
    logic            is_base;
    logic            is_mul;
    logic            is_div;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] ma;
    logic [XLEN-1:0] mb;

    assign is_base = ~op[4] & (op[3:0] <= 4'd9);
    assign is_mul  = (op[4:2] == 3'b100);
    assign is_div  = (op[4:2] == 3'b101);

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        case (op)
            OP_MULH:   begin sa = a[XLEN-1]; sb = b[XLEN-1]; end
            OP_MULHSU: sa = a[XLEN-1];
            OP_DIV:    begin sa = a[XLEN-1]; sb = b[XLEN-1]; end
            OP_REM:    begin sa = a[XLEN-1]; sb = b[XLEN-1]; end
            default:   begin sa = 1'b0; sb = 1'b0; end
        endcase
    end

    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;

    // ---------------- iterative step ----------------
    // mul: acc = {partial, multiplier}, shift right each step
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] mul_nxt;

    assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    assign mul_nxt = acc[0] ? {msum, acc[XLEN-1:1]}
                            : {1'b0, acc[2*XLEN-1:1]};

    // div: acc = {remainder, dividend/quotient}, shift left each step
    logic [XLEN:0]     dhi;
    logic              dge;
    logic [XLEN-1:0]   dsub;
    logic [XLEN-1:0]   dnew;
    logic [2*XLEN-1:0] div_nxt;

    assign dhi     = acc[2*XLEN-1:XLEN-1];
    assign dge     = dhi >= {1'b0, mcand};
    assign dsub    = dhi[XLEN-1:0] - mcand;
    assign dnew    = dge ? dsub : dhi[XLEN-1:0];
    assign div_nxt = {dnew, acc[XLEN-2:0], dge};

    logic [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0]   qv;
    logic [XLEN-1:0]   rv;
    logic [XLEN-1:0]   fin;
    logic [3:0]        fin_fl;
    logic [XLEN-1:0]   dz_res;
    logic [3:0]        dz_fl;
    logic              last;

    assign mul_p  = negq ? -mul_nxt : mul_nxt;
    assign qv     = negq ? -div_nxt[XLEN-1:0] : div_nxt[XLEN-1:0];
    assign rv     = negr ? -div_nxt[2*XLEN-1:XLEN]
                         : div_nxt[2*XLEN-1:XLEN];
    assign last   = (cnt == SHAMT_W'(XLEN-1));

    always_comb begin
        fin = '0;
        if (state == S_MUL)
            fin = (opr[1:0] == 2'b00) ? mul_p[XLEN-1:0]
                                      : mul_p[2*XLEN-1:XLEN];
        else
            fin = opr[1] ? rv : qv;
    end

    assign fin_fl = {2'b00, fin[XLEN-1], fin == '0};
    // divide by zero: quotient all ones, remainder = dividend
    assign dz_res = opr[1] ? aa : '1;
    assign dz_fl  = {2'b00, dz_res[XLEN-1], dz_res == '0};

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            opr    <= '0;
            acc    <= '0;
            mcand  <= '0;
            aa     <= '0;
            negq   <= 1'b0;
            negr   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opr <= op;
                        cnt <= '0;
                        unique case (1'b1)
                            is_base: begin
                                result <= base_res;
                                flags  <= base_fl;
                                state  <= S_DONE;
                            end
                            is_mul: begin
                                acc   <= {{XLEN{1'b0}}, mb};
                                mcand <= ma;
                                negq  <= sa ^ sb;
                                state <= S_MUL;
                            end
                            is_div: begin
                                acc   <= {{XLEN{1'b0}}, ma};
                                mcand <= mb;
                                aa    <= a;
                                negq  <= sa ^ sb;
                                negr  <= sa;
                                state <= S_DIV;
                            end
                            default: begin
                                result <= '0;
                                flags  <= '0;
                                state  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result <= fin;
                        flags  <= fin_fl;
                        state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (mcand == '0) begin
                        result <= dz_res;
                        flags  <= dz_fl;
                        state  <= S_DONE;
                    end else begin
                        acc <= div_nxt;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            result <= fin;
                            flags  <= fin_fl;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: randomized + directed bench for alu_mdu_seq.
// Reference model computes results with plain integer arithmetic.
module tb_alu_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    alu_mdu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic [4:0] o, input logic [31:0] x,
                             input logic [31:0] y, output logic [31:0] r,
                             output logic [3:0] f, output int l);
        longint sx, sy, ux, uy, t, ex, ey;
        logic [63:0] p;
        logic c, v, cv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        c = 1'b0; v = 1'b0; cv = 1'b0; l = 1; r = '0;
        // subtract-style carry/overflow, shared by sub/slt/sltu
        if (o == 5'h01 || o == 5'h05 || o == 5'h09) begin
            c  = (x >= y);
            t  = sx - sy;
            v  = (t > MAXS) || (t < MINS);
            cv = 1'b1;
        end
        case (o)
            5'h00: begin
                t  = ux + uy;
                r  = t[31:0];
                c  = (t > 64'sh0FFFFFFFF);
                t  = sx + sy;
                v  = (t > MAXS) || (t < MINS);
                cv = 1'b1;
            end
            5'h01: r = x - y;
            5'h02: r = x & y;
            5'h03: r = x | y;
            5'h04: r = x ^ y;
            5'h05: r = (sx < sy) ? 32'd1 : 32'd0;
            5'h06: r = x << y[4:0];
            5'h07: r = x >> y[4:0];
            5'h08: r = $signed(x) >>> y[4:0];
            5'h09: r = (x < y) ? 32'd1 : 32'd0;
            5'h10, 5'h11, 5'h12, 5'h13: begin
                l  = 33;
                ex = (o == 5'h11 || o == 5'h12) ? sx : ux;
                ey = (o == 5'h11) ? sy : uy;
                p  = ex * ey;
                r  = (o == 5'h10) ? p[31:0] : p[63:32];
            end
            5'h14, 5'h15, 5'h16, 5'h17: begin
                if (y == 32'd0) begin
                    l = 2;
                    r = o[1] ? x : 32'hFFFFFFFF;
                end else begin
                    l = 33;
                    if (o[0]) t = o[1] ? (ux % uy) : (ux / uy);
                    else      t = o[1] ? (sx % sy) : (sx / sy);
                    r = t[31:0];
                end
            end
            default: begin
                r  = '0;
                cv = 1'b0;
            end
        endcase
        f = {v & cv, c & cv, r[31], r == 32'd0};
        if (!(o <= 5'h09 || (o >= 5'h10 && o <= 5'h17))) f = 4'd0;
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int hold);
        logic [31:0] er;
        logic [3:0]  ef;
        int          el;
        int          lat;
        logic [31:0] r0;
        ref_model(o, x, y, er, ef, el);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
        chk($sformatf("latency op%0h", o), lat, el);
        chk($sformatf("result op%0h %h,%h", o, x, y), result, er);
        chk($sformatf("flags op%0h %h,%h", o, x, y), flags, ef);
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall_result", result, r0);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [4:0] ops [20];
        int seen;
        ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                5'h08, 5'h09, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15,
                5'h16, 5'h17, 5'h0A, 5'h1C};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        rst_n = 1'b1;

        run_op(5'h00, 32'h7FFFFFFF, 32'h1, 0);
        run_op(5'h01, 32'd5, 32'd5, 0);

        // reset during DIV cycle 10
        @(negedge clk);
        op = 5'h14; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result", result, 0);
        chk("midrst_flags", flags, 0);

        run_op(5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(5'h14, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(5'h16, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(5'h15, 32'd7, 32'd0, 0);
        run_op(5'h17, 32'd7, 32'd0, 0);
        run_op(5'h16, 32'hFFFFFFF9, 32'd2, 5);

        // flush at MUL cycle 4 with a competing request
        @(negedge clk);
        op = 5'h10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1; op = 5'h00; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_idle", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_quiet", seen, 0);
        run_op(5'h06, 32'd1, 32'd35, 0);

        // flush dominates out_ready while holding a result
        @(negedge clk);
        op = 5'h00; a = 32'd2; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fd_valid", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("fd_dropped", out_valid, 0);
        chk("fd_in_ready", in_ready, 1);

        for (int i = 0; i < 80; i++)
            run_op(ops[$urandom_range(0, 19)], rnd_val(), rnd_val(),
                   $urandom_range(0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
